// File: rtl/regfile_port_arbiter.sv
// Two-requester arbiter for a 1R/1W register file: round-robin single issue, dual issue on read+write, lock with timeout.
// Optional macro REGFILE_ARB_FWD_EN forwards concurrent write data to a same-index dual-issue read.
module regfile_port_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int INDEX_WIDTH  = 2,
  parameter int LOCK_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_req_valid,
  input  logic                   a_req_write,
  input  logic [INDEX_WIDTH-1:0] a_req_index,
  input  logic [DATA_WIDTH-1:0]  a_req_wdata,
  input  logic                   a_req_lock,
  output logic                   a_req_ready,
  output logic                   a_rsp_valid,
  output logic [DATA_WIDTH-1:0]  a_rsp_data,
  input  logic                   b_req_valid,
  input  logic                   b_req_write,
  input  logic [INDEX_WIDTH-1:0] b_req_index,
  input  logic [DATA_WIDTH-1:0]  b_req_wdata,
  input  logic                   b_req_lock,
  output logic                   b_req_ready,
  output logic                   b_rsp_valid,
  output logic [DATA_WIDTH-1:0]  b_rsp_data,
  output logic [INDEX_WIDTH-1:0] rf_read_index,
  input  logic [DATA_WIDTH-1:0]  rf_read_data,
  output logic [INDEX_WIDTH-1:0] rf_write_index,
  output logic                   rf_write_enable,
  output logic [DATA_WIDTH-1:0]  rf_write_data,
  output logic [1:0]             lock_owner,
  output logic                   timeout_pulse
);

  typedef enum logic [1:0] {IDLE = 2'b00, OWN_A = 2'b01, OWN_B = 2'b10} state_t;

  localparam int CNT_W        = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int TIMEOUT_LAST = (LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0;

  state_t                state_reg, state_next;
  logic                  rr_ptr_reg, rr_ptr_next;   // 0 = A has priority, 1 = B
  logic [CNT_W-1:0]      lock_cnt_reg, lock_cnt_next;
  logic                  timeout_reg, timeout_next;
  logic                  a_rsp_valid_reg, b_rsp_valid_reg;
  logic [DATA_WIDTH-1:0] a_rsp_data_reg, b_rsp_data_reg;

  logic grant_a, grant_b;
  logic a_rd, a_wr, b_rd, b_wr;
  logic contention, lock_a, lock_b, timeout_hit;
  logic [DATA_WIDTH-1:0] read_value;

  assign contention  = a_req_valid && b_req_valid && (a_req_write == b_req_write);
  assign timeout_hit = (LOCK_TIMEOUT != 0) && (lock_cnt_reg == CNT_W'(TIMEOUT_LAST));

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_reg)
      IDLE: begin
        if (contention) begin
          grant_a = ~rr_ptr_reg;
          grant_b = rr_ptr_reg;
        end else begin
          grant_a = a_req_valid;
          grant_b = b_req_valid;
        end
      end
      OWN_A:   grant_a = a_req_valid;
      OWN_B:   grant_b = b_req_valid;
      default: ;
    endcase
    if (!reset) begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end
  end

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;
  assign a_rd = grant_a & ~a_req_write;
  assign a_wr = grant_a &  a_req_write;
  assign b_rd = grant_b & ~b_req_write;
  assign b_wr = grant_b &  b_req_write;
  assign lock_a = grant_a & a_req_lock;
  assign lock_b = grant_b & b_req_lock;

  // Dual issue only pairs a read with a write, so each port has at most one source.
  always_comb begin
    rf_read_index   = '0;
    rf_write_index  = '0;
    rf_write_data   = '0;
    rf_write_enable = 1'b0;
    if (a_rd)      rf_read_index = a_req_index;
    else if (b_rd) rf_read_index = b_req_index;
    if (a_wr) begin
      rf_write_enable = 1'b1;
      rf_write_index  = a_req_index;
      rf_write_data   = a_req_wdata;
    end else if (b_wr) begin
      rf_write_enable = 1'b1;
      rf_write_index  = b_req_index;
      rf_write_data   = b_req_wdata;
    end
  end

`ifdef REGFILE_ARB_FWD_EN
  assign read_value = (rf_write_enable && (rf_write_index == rf_read_index)) ? rf_write_data : rf_read_data;
`else
  assign read_value = rf_read_data;
`endif

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    lock_cnt_next = lock_cnt_reg;
    timeout_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        lock_cnt_next = '0;
        if (contention) rr_ptr_next = ~rr_ptr_reg;
        // Both locking in a dual issue: the priority holder takes ownership.
        if (lock_a && (!lock_b || !rr_ptr_reg)) state_next = OWN_A;
        else if (lock_b)                        state_next = OWN_B;
      end
      OWN_A: begin
        lock_cnt_next = lock_cnt_reg + 1'b1;
        if ((grant_a && !a_req_lock) || timeout_hit) begin
          state_next    = IDLE;
          rr_ptr_next   = 1'b1;
          lock_cnt_next = '0;
          timeout_next  = ~(grant_a && !a_req_lock);
        end
      end
      OWN_B: begin
        lock_cnt_next = lock_cnt_reg + 1'b1;
        if ((grant_b && !b_req_lock) || timeout_hit) begin
          state_next    = IDLE;
          rr_ptr_next   = 1'b0;
          lock_cnt_next = '0;
          timeout_next  = ~(grant_b && !b_req_lock);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= 1'b0;
      lock_cnt_reg    <= '0;
      timeout_reg     <= 1'b0;
      a_rsp_valid_reg <= 1'b0;
      b_rsp_valid_reg <= 1'b0;
      a_rsp_data_reg  <= '0;
      b_rsp_data_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      lock_cnt_reg    <= lock_cnt_next;
      timeout_reg     <= timeout_next;
      a_rsp_valid_reg <= a_rd;
      b_rsp_valid_reg <= b_rd;
      if (a_rd) a_rsp_data_reg <= read_value;
      if (b_rd) b_rsp_data_reg <= read_value;
    end
  end

  assign a_rsp_valid   = a_rsp_valid_reg;
  assign b_rsp_valid   = b_rsp_valid_reg;
  assign a_rsp_data    = a_rsp_data_reg;
  assign b_rsp_data    = b_rsp_data_reg;
  assign lock_owner    = state_reg;
  assign timeout_pulse = timeout_reg;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed self-checking bench for regfile_port_arbiter with a behavioural 4x16 register file.
module tb_regfile_port_arbiter;
  localparam int DW = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          a_req_valid, a_req_write, a_req_lock, a_req_ready, a_rsp_valid;
  logic [IW-1:0] a_req_index;
  logic [DW-1:0] a_req_wdata, a_rsp_data;
  logic          b_req_valid, b_req_write, b_req_lock, b_req_ready, b_rsp_valid;
  logic [IW-1:0] b_req_index;
  logic [DW-1:0] b_req_wdata, b_rsp_data;
  logic [IW-1:0] rf_read_index, rf_write_index;
  logic [DW-1:0] rf_read_data, rf_write_data;
  logic          rf_write_enable, timeout_pulse;
  logic [1:0]    lock_owner;

  regfile_port_arbiter #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .LOCK_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_write(a_req_write), .a_req_index(a_req_index),
    .a_req_wdata(a_req_wdata), .a_req_lock(a_req_lock), .a_req_ready(a_req_ready),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_write(b_req_write), .b_req_index(b_req_index),
    .b_req_wdata(b_req_wdata), .b_req_lock(b_req_lock), .b_req_ready(b_req_ready),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .rf_read_index(rf_read_index), .rf_read_data(rf_read_data),
    .rf_write_index(rf_write_index), .rf_write_enable(rf_write_enable),
    .rf_write_data(rf_write_data), .lock_owner(lock_owner), .timeout_pulse(timeout_pulse)
  );

  // Register file: combinational read, clocked write.
  logic [DW-1:0] rf_mem [4];
  initial for (int i = 0; i < 4; i++) rf_mem[i] <= '0;
  assign rf_read_data = rf_mem[rf_read_index];
  always @(posedge clk) if (rf_write_enable) rf_mem[rf_write_index] <= rf_write_data;

  int checks_total  = 0;
  int checks_passed = 0;
  int txn_count     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_a(input logic v, input logic w, input logic [IW-1:0] idx,
                         input logic [DW-1:0] d, input logic lk);
    a_req_valid = v; a_req_write = w; a_req_index = idx; a_req_wdata = d; a_req_lock = lk;
  endtask

  task automatic drive_b(input logic v, input logic w, input logic [IW-1:0] idx,
                         input logic [DW-1:0] d, input logic lk);
    b_req_valid = v; b_req_write = w; b_req_index = idx; b_req_wdata = d; b_req_lock = lk;
  endtask

  task automatic tick();
    $display("txn %0d: rst=%0b A(v=%0b w=%0b i=%0d d=%h l=%0b rdy=%0b) B(v=%0b w=%0b i=%0d d=%h l=%0b rdy=%0b) owner=%0d",
             txn_count, reset, a_req_valid, a_req_write, a_req_index, a_req_wdata, a_req_lock, a_req_ready,
             b_req_valid, b_req_write, b_req_index, b_req_wdata, b_req_lock, b_req_ready, lock_owner);
    txn_count++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a_grants;
    logic [DW-1:0] dual_exp;

    // Test 1: reset, then write followed by read of the same index
    reset = 1'b0;
    drive_a(1, 1, 2'd1, 16'h1234, 0);
    drive_b(0, 0, 2'd0, 16'h0000, 0);
    #1;
    check("rst_a_ready", a_req_ready, 0);
    check("rst_we", rf_write_enable, 0);
    tick(); tick();
    check("rst_owner", lock_owner, 0);
    check("rst_a_rsp_valid", a_rsp_valid, 0);
    check("rst_b_rsp_valid", b_rsp_valid, 0);
    check("rst_a_rsp_data", a_rsp_data, 0);
    check("rst_b_rsp_data", b_rsp_data, 0);
    check("rst_timeout", timeout_pulse, 0);
    reset = 1'b1;
    #1;
    check("t1_a_ready", a_req_ready, 1);
    check("t1_we", rf_write_enable, 1);
    check("t1_widx", rf_write_index, 1);
    check("t1_wdata", rf_write_data, 16'h1234);
    tick();
    drive_a(0, 0, 2'd0, 16'h0000, 0);
    drive_b(1, 0, 2'd1, 16'h0000, 0);
    #1;
    check("t1_b_ready", b_req_ready, 1);
    check("t1_ridx", rf_read_index, 1);
    tick();
    check("t1_b_rsp_valid", b_rsp_valid, 1);
    check("t1_b_rsp_data", b_rsp_data, 16'h1234);
    check("t1_a_rsp_valid", a_rsp_valid, 0);
    drive_b(0, 0, 2'd0, 16'h0000, 0);
    tick();
    check("t1_b_rsp_pulse_end", b_rsp_valid, 0);

    // Test 2: both read every cycle, grants alternate A,B,A,B
    drive_a(1, 0, 2'd1, 16'h0000, 0);
    drive_b(1, 0, 2'd3, 16'h0000, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_a_ready", a_req_ready, (i % 2 == 0));
      check("t2_b_ready", b_req_ready, (i % 2 == 1));
      check("t2_ridx", rf_read_index, (i % 2 == 0) ? 1 : 3);
      tick();
      check("t2_a_rsp_valid", a_rsp_valid, (i % 2 == 0));
      check("t2_b_rsp_valid", b_rsp_valid, (i % 2 == 1));
      if (i == 0) check("t2_a_rsp_data", a_rsp_data, 16'h1234);
    end

    // Test 3: preload idx2, then same-index dual issue
    drive_a(0, 0, 2'd0, 16'h0000, 0);
    drive_b(1, 1, 2'd2, 16'h0F0F, 0);
    #1;
    check("t3_pre_b_ready", b_req_ready, 1);
    tick();
    drive_a(1, 1, 2'd2, 16'hBEEF, 0);
    drive_b(1, 0, 2'd2, 16'h0000, 0);
    #1;
    check("t3_a_ready", a_req_ready, 1);
    check("t3_b_ready", b_req_ready, 1);
    check("t3_we", rf_write_enable, 1);
    check("t3_ridx", rf_read_index, 2);
    check("t3_widx", rf_write_index, 2);
    tick();
`ifdef REGFILE_ARB_FWD_EN
    dual_exp = 16'hBEEF;
`else
    dual_exp = 16'h0F0F;
`endif
    check("t3_b_rsp_valid", b_rsp_valid, 1);
    check("t3_b_rsp_data", b_rsp_data, dual_exp);
    drive_a(0, 0, 2'd0, 16'h0000, 0);
    #1;
    tick();
    check("t3_b_rsp_new", b_rsp_data, 16'hBEEF);

    // Test 4: A locks with a read, releases with a write; B blocked meanwhile
    drive_a(1, 0, 2'd1, 16'h0000, 1);
    drive_b(1, 0, 2'd1, 16'h0000, 0);
    #1;
    check("t4_a_ready", a_req_ready, 1);
    check("t4_b_ready", b_req_ready, 0);
    tick();
    check("t4_owner_a", lock_owner, 2'b01);
    check("t4_a_rsp_valid", a_rsp_valid, 1);
    check("t4_a_rsp_data", a_rsp_data, 16'h1234);
    drive_a(1, 1, 2'd1, 16'h4321, 0);
    #1;
    check("t4_a_ready_wr", a_req_ready, 1);
    check("t4_b_blocked", b_req_ready, 0);
    check("t4_we", rf_write_enable, 1);
    tick();
    check("t4_owner_none", lock_owner, 2'b00);
    drive_a(0, 0, 2'd0, 16'h0000, 0);
    #1;
    check("t4_b_ready", b_req_ready, 1);
    tick();
    check("t4_b_rsp_valid", b_rsp_valid, 1);
    check("t4_b_rsp_data", b_rsp_data, 16'h4321);

    // Test 5: A holds the lock until the timeout forces release
    drive_b(0, 0, 2'd0, 16'h0000, 0);
    drive_a(1, 0, 2'd1, 16'h0000, 1);
    #1;
    check("t5_entry_ready", a_req_ready, 1);
    tick();
    check("t5_owner_a", lock_owner, 2'b01);
    drive_b(1, 0, 2'd2, 16'h0000, 0);
    a_grants = 0;
    for (int i = 0; i < 20 && lock_owner == 2'b01; i++) begin
      #1;
      if (a_req_ready) a_grants++;
      check("t5_b_blocked", b_req_ready, 0);
      check("t5_no_pulse", timeout_pulse, 0);
      tick();
    end
    check("t5_a_grants", a_grants, 8);
    check("t5_owner_none", lock_owner, 2'b00);
    check("t5_pulse", timeout_pulse, 1);
    check("t5_b_ready", b_req_ready, 1);
    check("t5_a_ready", a_req_ready, 0);
    tick();
    check("t5_pulse_end", timeout_pulse, 0);
    check("t5_b_rsp_valid", b_rsp_valid, 1);
    check("t5_b_rsp_data", b_rsp_data, 16'hBEEF);

    // Test 6: reset while B owns the lock with a read accepted
    drive_a(0, 0, 2'd0, 16'h0000, 0);
    drive_b(1, 0, 2'd2, 16'h0000, 1);
    #1;
    check("t6_b_ready", b_req_ready, 1);
    tick();
    check("t6_owner_b", lock_owner, 2'b10);
    drive_b(1, 0, 2'd1, 16'h0000, 1);
    drive_a(1, 1, 2'd0, 16'h9999, 0);
    #1;
    check("t6_a_blocked_own", a_req_ready, 0);
    reset = 1'b0;
    #1;
    check("t6_rst_b_ready", b_req_ready, 0);
    check("t6_rst_a_ready", a_req_ready, 0);
    check("t6_rst_we", rf_write_enable, 0);
    tick();
    check("t6_owner_none", lock_owner, 2'b00);
    check("t6_b_rsp_valid", b_rsp_valid, 0);
    check("t6_b_rsp_data", b_rsp_data, 0);
    check("t6_rf0_untouched", rf_mem[0], 0);
    reset = 1'b1;
    drive_b(0, 0, 2'd0, 16'h0000, 0);
    drive_a(1, 0, 2'd1, 16'h0000, 0);
    #1;
    check("t6_post_a_ready", a_req_ready, 1);
    tick();
    check("t6_post_a_rsp_valid", a_rsp_valid, 1);
    check("t6_post_a_rsp_data", a_rsp_data, 16'h4321);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares one 4-entry x 16-bit register file between two requesters, A and B.
- The register file has 1 combinational read port and 1 clocked write port.
- Per cycle: single-issue round-robin arbitration, or dual-issue when one requester reads and the other writes.
- Supports a lock (ownership) mode for read-modify-write sequences, bounded by a timeout.
- Sits between the two execution clients and the register file, and drives all register file ports.

Parameters:
DATA_WIDTH, 16, register data width
INDEX_WIDTH, 2, register index width (2**INDEX_WIDTH entries)
LOCK_TIMEOUT, 8, max cycles in a locked state before forced release; 0 disables the timeout

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-low (reset==0 resets)
a_req_valid  in  1  A request present
a_req_write  in  1  1=write, 0=read
a_req_index  in  INDEX_WIDTH  target register
a_req_wdata  in  DATA_WIDTH  write data
a_req_lock  in  1  keep ownership after this transaction
a_req_ready  out  1  A request accepted this cycle (combinational)
a_rsp_valid  out  1  read data valid, 1-cycle pulse
a_rsp_data  out  DATA_WIDTH  read data (registered)
b_* (same 8 signals as A)  --  requester B
rf_read_index  out  INDEX_WIDTH  to register file read port
rf_read_data  in  DATA_WIDTH  from register file read port
rf_write_index  out  INDEX_WIDTH  to register file write port
rf_write_enable  out  1  register file write strobe
rf_write_data  out  DATA_WIDTH  register file write data
lock_owner  out  2  00=none, 01=A, 10=B (registered state)
timeout_pulse  out  1  1-cycle pulse after a forced lock release

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, rr_ptr=A, lock_cnt=0.
  - *_rsp_valid=0, *_rsp_data=0, timeout_pulse=0.
  - While reset==0: both ready=0 and rf_write_enable=0 (combinational gating).
  - Reset mid-lock drops ownership; no response is issued for that cycle's transaction.
- FSM states: IDLE, OWN_A, OWN_B.
- IDLE, one requester valid: that request is accepted.
- IDLE, both valid with opposite ops: dual issue, both ready=1. The read uses the read port, the write uses the write port.
- IDLE, both valid with the same op:
  - rr_ptr requester wins; the other gets ready=0.
  - rr_ptr toggles to the loser at the edge.
  - rr_ptr changes only on contention or lock release.
- OWN_x: only x may be accepted; the other's ready=0. No dual issue.
- Write accepted: rf_write_enable=1, rf_write_index/rf_write_data = requester's fields. Commits at that edge.
- Read accepted:
  - rf_read_index = requester's index.
  - rf_read_data is captured into x_rsp_data at the edge; x_rsp_valid=1 for exactly the next cycle.
  - x_rsp_data holds until the next read by x.
  - Latency is 1 cycle. The response has no backpressure.
- Idle port defaults: rf_read_index=0, rf_write_index=0, rf_write_data=0.
- Lock entry: a request accepted in IDLE with req_lock=1 moves the FSM to OWN_x and clears lock_cnt.
  - In a dual-issue cycle only one lock may be taken. If both assert lock, the rr_ptr requester wins and the other's lock bit is ignored; its transaction still completes.
- Lock release: owner's accepted request with req_lock=0 goes to IDLE and sets rr_ptr to the other requester.
  - Owner dropping req_valid does not release the lock.
- Lock counter: lock_cnt increments every cycle in OWN_x.
- Timeout: when LOCK_TIMEOUT!=0 and lock_cnt==LOCK_TIMEOUT-1 in OWN_x:
  - The owner's request, if valid, is still served, but its req_lock is ignored.
  - Next state is IDLE, rr_ptr = other requester.
  - timeout_pulse=1 in the following cycle.
  - A voluntary release in the same cycle takes precedence and gives no pulse.
- Same-index dual issue (read and write to the same register in one cycle): the read returns the pre-write value, unless the optional feature is enabled.
- A write followed by a read of the same index in the next cycle returns the new value.

Optional Feature:
REGFILE_ARB_FWD_EN
- Defined: on dual issue with equal indices, the read response data equals the concurrent write data (write-to-read forwarding).
- Undefined: the read response data equals the old register contents. No forwarding mux is present.

Test Plan:
1. Reset low 2 cycles, then A write idx1=0x1234, next cycle B read idx1 -> rf_write_enable=1 in the write cycle; b_rsp_valid pulses 1 cycle later with b_rsp_data=0x1234.
2. A and B both read every cycle for 4 cycles -> grants alternate A,B,A,B; each rsp_valid pulses one cycle after its own grant.
3. A write idx2=0xBEEF and B read idx2 in the same cycle -> both ready=1; b_rsp_data=old value (0xBEEF with REGFILE_ARB_FWD_EN).
4. A read with lock=1, then A write with lock=0 while B requests continuously -> b_req_ready=0 until the cycle after the A write; lock_owner 01 then 00.
5. A holds lock=1 and requests every cycle, LOCK_TIMEOUT=8 -> 8 A grants; lock_owner=00 afterwards; timeout_pulse=1 for one cycle; B granted on the next cycle.
6. Reset driven low during OWN_B with a B read accepted -> no b_rsp_valid; lock_owner=00; ready=0 while reset==0.
